// File: rtl/arm7_pkg.sv
// ============================================================================
// Module      : arm7_pkg
// Description : Shared ARM7 register-file types and constants.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package arm7_pkg;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    typedef struct packed {
        logic        read_en;
        logic [3:0]  read_reg;
        logic        write_en;
        logic [3:0]  write_reg;
        logic [31:0] write_value;
        logic        write_restore_from_SPSR;
    } rf_req_t;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_OWNED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_port_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector; first set bit from start.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan downwards so the last hit written is the nearest one to start.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// Module      : regfile_port_arbiter
// Description : Round-robin owner of the shared register-file port, with
//               control forwarding, hold-time and intrusion policing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_port_arbiter
    import arm7_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_HOLD = 15,
    localparam int IW      = $clog2(N),
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    input  logic [N-1:0]    u_read_en,
    input  logic [4*N-1:0]  u_read_reg,
    input  logic [N-1:0]    u_write_en,
    input  logic [4*N-1:0]  u_write_reg,
    input  logic [32*N-1:0] u_write_value,
    input  logic [N-1:0]    u_write_restore_from_SPSR,
    output logic [31:0]     read_value,
    output logic            rf_read_en,
    output logic [3:0]      rf_read_reg,
    output logic            rf_write_en,
    output logic [3:0]      rf_write_reg,
    output logic [31:0]     rf_write_value,
    output logic            rf_write_restore_from_SPSR,
    input  logic [31:0]     rf_read_value,
    output logic [IW-1:0]   owner,
    output logic            busy,
    output logic            err
);

    logic [0:0]    r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic          r_err;
    logic          w_err_set;
    logic          w_busy;
    logic          w_owner_req;
    logic          w_fwd;
    logic [IW-1:0] w_start;
    logic [N-1:0]  w_pick_req;
    logic          w_found;
    logic [IW-1:0] w_idx;
    rf_req_t       w_sel;

    assign w_busy      = (r_state == ARB_OWNED);
    assign w_owner_req = req[r_owner];
    assign w_fwd       = w_busy & w_owner_req;

    // ptr always equals the owner while OWNED, so one start serves both
    // the idle grant and the release handoff; the owner is masked out.
    assign w_start    = (r_ptr == IW'(N - 1)) ? '0 : r_ptr + IW'(1);
    assign w_pick_req = w_busy ? (req & ~r_gnt) : req;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req   (w_pick_req),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= IW'(N - 1);
            r_hold  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_OWNED;
                    w_gnt_nxt   = N'(1) << w_idx;
                    w_owner_nxt = w_idx;
                    w_ptr_nxt   = w_idx;
                    w_hold_nxt  = '0;
                end
            end
            ARB_OWNED: begin
                if (w_owner_req) begin
                    if (r_hold != HW'(MAX_HOLD)) begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end else if (w_found) begin
                    w_gnt_nxt   = N'(1) << w_idx;
                    w_owner_nxt = w_idx;
                    w_ptr_nxt   = w_idx;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = ARB_IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_sel = '0;
        if (w_fwd) begin
            w_sel.read_en                 = u_read_en[r_owner];
            w_sel.read_reg                = u_read_reg[r_owner*4 +: 4];
            w_sel.write_en                = u_write_en[r_owner];
            w_sel.write_reg               = u_write_reg[r_owner*4 +: 4];
            w_sel.write_value             = u_write_value[r_owner*32 +: 32];
            w_sel.write_restore_from_SPSR = u_write_restore_from_SPSR[r_owner];
        end
    end

    assign w_err_set = (w_fwd & (r_hold == HW'(MAX_HOLD)))
                     | (|((u_read_en | u_write_en) & ~r_gnt))
                     | (|(r_gnt & (r_gnt - N'(1))));

    assign gnt                        = r_gnt;
    assign owner                      = r_owner;
    assign busy                       = w_busy;
    assign err                        = r_err;
    assign read_value                 = rf_read_value;
    assign rf_read_en                 = w_sel.read_en;
    assign rf_read_reg                = w_sel.read_reg;
    assign rf_write_en                = w_sel.write_en;
    assign rf_write_reg               = w_sel.write_reg;
    assign rf_write_value             = w_sel.write_value;
    assign rf_write_restore_from_SPSR = w_sel.write_restore_from_SPSR;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// ============================================================================
// Module      : tb_regfile_port_arbiter
// Description : Self-checking bench for regfile_port_arbiter (N=3).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_port_arbiter;
    import arm7_pkg::*;

    localparam int N        = 3;
    localparam int MAX_HOLD = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    u_read_en = '0;
    logic [4*N-1:0]  u_read_reg = '0;
    logic [N-1:0]    u_write_en = '0;
    logic [4*N-1:0]  u_write_reg = '0;
    logic [32*N-1:0] u_write_value = '0;
    logic [N-1:0]    u_write_restore_from_SPSR = '0;
    logic [31:0]     read_value;
    logic            rf_read_en;
    logic [3:0]      rf_read_reg;
    logic            rf_write_en;
    logic [3:0]      rf_write_reg;
    logic [31:0]     rf_write_value;
    logic            rf_write_restore_from_SPSR;
    logic [31:0]     rf_read_value = 32'h0BAD_F00D;
    logic [1:0]      owner;
    logic            busy;
    logic            err;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_port_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .req                        (req),
        .gnt                        (gnt),
        .u_read_en                  (u_read_en),
        .u_read_reg                 (u_read_reg),
        .u_write_en                 (u_write_en),
        .u_write_reg                (u_write_reg),
        .u_write_value              (u_write_value),
        .u_write_restore_from_SPSR  (u_write_restore_from_SPSR),
        .read_value                 (read_value),
        .rf_read_en                 (rf_read_en),
        .rf_read_reg                (rf_read_reg),
        .rf_write_en                (rf_write_en),
        .rf_write_reg               (rf_write_reg),
        .rf_write_value             (rf_write_value),
        .rf_write_restore_from_SPSR (rf_write_restore_from_SPSR),
        .rf_read_value              (rf_read_value),
        .owner                      (owner),
        .busy                       (busy),
        .err                        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner is an integer (-1 = nobody), last winner is remembered.
    int m_own = -1, m_ptr = N - 1, m_hold = 0;
    bit m_err = 1'b0;
    int n_own, n_ptr, n_hold;
    bit n_err;

    function automatic int first_from(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    always_comb begin
        logic [N-1:0] others;
        int w;
        n_own  = m_own;
        n_ptr  = m_ptr;
        n_hold = m_hold;
        n_err  = m_err;
        others = req;
        w      = -1;
        for (int i = 0; i < N; i++)
            if ((u_read_en[i] || u_write_en[i]) && i != m_own) n_err = 1'b1;
        if (m_own >= 0 && req[m_own] && m_hold == MAX_HOLD) n_err = 1'b1;
        if (m_own < 0) begin
            w = first_from(req, m_ptr + 1);
            if (w >= 0) begin n_own = w; n_ptr = w; n_hold = 0; end
        end else if (req[m_own]) begin
            if (m_hold < MAX_HOLD) n_hold = m_hold + 1;
        end else begin
            others[m_own] = 1'b0;
            w = first_from(others, m_own + 1);
            n_own  = w;
            n_hold = 0;
            if (w >= 0) n_ptr = w;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own <= -1; m_ptr <= N - 1; m_hold <= 0; m_err <= 1'b0;
        end else begin
            m_own <= n_own; m_ptr <= n_ptr; m_hold <= n_hold; m_err <= n_err;
        end
    end

    always @(negedge clk) begin
        int  oi;
        bit  g;
        oi = (m_own < 0) ? 0 : m_own;
        g  = (m_own >= 0) && req[oi];
        chk("cyc_gnt", gnt, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        chk("cyc_busy", busy, m_own >= 0);
        if (m_own >= 0) chk("cyc_owner", owner, m_own);
        chk("cyc_err", err, m_err);
        chk("cyc_rd_en", rf_read_en, g ? u_read_en[oi] : 1'b0);
        chk("cyc_rd_reg", rf_read_reg, g ? u_read_reg[oi*4 +: 4] : 4'd0);
        chk("cyc_wr_en", rf_write_en, g ? u_write_en[oi] : 1'b0);
        chk("cyc_wr_reg", rf_write_reg, g ? u_write_reg[oi*4 +: 4] : 4'd0);
        chk("cyc_wr_val", rf_write_value, g ? u_write_value[oi*32 +: 32] : 32'd0);
        chk("cyc_spsr", rf_write_restore_from_SPSR, g ? u_write_restore_from_SPSR[oi] : 1'b0);
        chk("cyc_rd_val", read_value, rf_read_value);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; u_read_en = '0; u_write_en = '0; u_read_reg = '0;
        u_write_reg = '0; u_write_value = '0; u_write_restore_from_SPSR = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_en", rf_write_en, 0);
        rst_n = 1'b1;
        step(1);

        // Single requester writes LR
        req = 3'b001;
        step(1);
        #1 chk("single_gnt", gnt, 3'b001);
        u_write_en = 3'b001;
        u_write_reg[3:0] = REG_LR;
        u_write_value[31:0] = 32'h0000_1004;
        rf_read_value = 32'h1234_5678;
        #1;
        chk("single_wr_en", rf_write_en, 1);
        chk("single_wr_reg", rf_write_reg, 14);
        chk("single_wr_val", rf_write_value, 32'h0000_1004);
        chk("single_rd_val", read_value, 32'h1234_5678);
        step(1);
        u_write_en = '0;
        req = '0;
        step(1);
        #1 chk("single_idle", busy, 0);

        // Rotation 0,1,2,0 with no idle cycles
        do_reset();
        req = 3'b111;
        step(1);
        for (int g = 0; g < 4; g++) begin
            int e;
            e = g % N;
            #1 chk("rot_gnt", gnt, 32'd1 << e);
            chk("rot_busy", busy, 1);
            step(3);
            req = 3'b111 & ~(3'b001 << e);
            step(1);
            req = 3'b111;
        end
        req = '0;
        step(1);
        #1 chk("rot_idle", busy, 0);

        // Back-to-back handoff 1 -> 2
        req = 3'b010;
        step(1);
        #1 chk("b2b_own1", gnt, 3'b010);
        req = 3'b110;
        u_write_en = 3'b010;
        u_write_reg[7:4] = 4'd5;
        u_write_value[63:32] = 32'h0000_0055;
        u_write_restore_from_SPSR = 3'b010;
        step(1);
        #1 chk("b2b_wr_en", rf_write_en, 1);
        req = 3'b100;
        #1;
        chk("b2b_drop_wr", rf_write_en, 0);
        chk("b2b_drop_busy", busy, 1);
        step(1);
        u_write_en = '0;
        u_write_restore_from_SPSR = '0;
        #1;
        chk("b2b_gnt", gnt, 3'b100);
        chk("b2b_busy", busy, 1);
        chk("b2b_err", err, 0);
        req = '0;
        step(1);

        // Intrusion by unit 2 while unit 0 owns
        req = 3'b001;
        step(1);
        #1 chk("intr_gnt", gnt, 3'b001);
        u_read_en = 3'b001;
        u_read_reg[3:0] = 4'd2;
        u_write_en = 3'b101;
        u_write_reg[3:0] = 4'd3;
        u_write_value[31:0] = 32'hA5A5_A5A5;
        u_write_reg[11:8] = REG_PC;
        u_write_value[95:64] = 32'hDEAD_BEEF;
        #1;
        chk("intr_wr_reg", rf_write_reg, 3);
        chk("intr_wr_val", rf_write_value, 32'hA5A5_A5A5);
        chk("intr_err0", err, 0);
        step(1);
        u_write_en = 3'b001;
        #1 chk("intr_err1", err, 1);
        step(3);
        chk("intr_sticky", err, 1);
        clear_inputs();
        step(1);

        // Hold timeout
        do_reset();
        req = 3'b001;
        step(1);
        step(15);
        chk("hold_err_before", err, 0);
        step(1);
        chk("hold_err_set", err, 1);
        chk("hold_gnt_kept", gnt, 3'b001);
        step(3);
        req = '0;
        step(1);

        // Reset while unit 1 writes
        req = 3'b010;
        step(1);
        #1 chk("mid_gnt", gnt, 3'b010);
        u_write_en = 3'b010;
        u_write_reg[7:4] = 4'd2;
        u_write_value[63:32] = 32'h0000_0077;
        #1 chk("mid_wr_en", rf_write_en, 1);
        chk("mid_err_pre", err, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_wr", rf_write_en, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_busy", busy, 0);
        clear_inputs();
        step(2);
        rst_n = 1'b1;
        req = 3'b011;
        step(1);
        #1 chk("post_rst_gnt", gnt, 3'b001);
        req = '0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
